inst_fetch: RTL

- Instruction fetch stage producing the pc/instruction pair consumed by the decode stage (via the IF/ID register).
- Fetches each 32-bit instruction as four byte reads over a byte-wide, arbitrated memory read port and assembles it little-endian.
- Applies static next-PC prediction and reports it on jmp_status_o.
- Honours pipeline stall and EX-stage redirect/flush.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch_predict.sv | 31 +++
 rtl/inst_fetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package inst_fetch_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;

    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_WAIT  = 2'd2
    } if_state_e;

endpackage

// File: rtl/inst_fetch_predict.sv
// Static next-PC predictor: JAL and backward branches taken, everything else pc+4.
module fetch_predict
    import inst_fetch_pkg::*;
(
    input  logic [INST_W-1:0]      word_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    output logic                   pred_taken_o,
    output logic [INST_ADDR_W-1:0] pred_next_pc_o
);

    logic [31:0] jal_off;
    logic [31:0] br_off;

    assign jal_off = {{11{word_i[31]}}, word_i[31], word_i[19:12], word_i[20],
                      word_i[30:21], 1'b0};
    assign br_off  = {{19{word_i[31]}}, word_i[31], word_i[7], word_i[30:25],
                      word_i[11:8], 1'b0};

    always_comb begin
        pred_taken_o   = 1'b0;
        pred_next_pc_o = pc_i + 32'd4;
        if (word_i[6:0] == OP_JAL) begin
            pred_taken_o   = 1'b1;
            pred_next_pc_o = pc_i + jal_off;
        end else if (word_i[6:0] == OP_BRANCH && word_i[31]) begin
            pred_taken_o   = 1'b1;
            pred_next_pc_o = pc_i + br_off;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: four pipelined byte reads per instruction, little-endian assembly,
// static prediction, stall hold and EX redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       flush_target_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_din_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic              jmp_status_o
);

    if_state_e   state_q;
    logic [31:0] fpc_q;
    logic [2:0]  iss_q;
    logic [2:0]  rcv_q;
    logic        pend_q;
    logic        drop_q;
    logic [7:0]  buf_q [3];
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;
    logic        jmp_q;

    logic        req;
    logic        grant;
    logic        byte_ok;
    logic [31:0] addr_sum;
    logic [31:0] word_d;
    logic        pred_taken;
    logic [31:0] pred_next_pc;

    assign req      = (state_q == IF_FETCH) && !iss_q[2];
    assign grant    = req && mem_gnt_i;
    // A byte is only ours if it answers a grant made outside a flush cycle.
    assign byte_ok  = pend_q && !drop_q && (state_q == IF_FETCH);
    assign addr_sum = fpc_q + {29'd0, iss_q};
    assign word_d   = {mem_din_i, buf_q[2], buf_q[1], buf_q[0]};

    assign mem_req_o    = req;
    assign mem_addr_o   = req ? addr_sum[ADDR_W-1:0] : '0;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign jmp_status_o = jmp_q;

    fetch_predict u_predict (
        .word_i         (word_d),
        .pc_i           (fpc_q),
        .pred_taken_o   (pred_taken),
        .pred_next_pc_o (pred_next_pc)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (rst == RST_ENABLE) begin
                buf_q[gi] <= 8'h00;
            end else if (!flush_i && byte_ok && rcv_q == 3'(gi)) begin
                buf_q[gi] <= mem_din_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= IF_IDLE;
            fpc_q   <= RESET_PC;
            iss_q   <= 3'd0;
            rcv_q   <= 3'd0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            pc_q    <= ZERO_WORD;
            inst_q  <= ZERO_WORD;
            valid_q <= 1'b0;
            jmp_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IF_FETCH;
            fpc_q   <= flush_target_i;
            iss_q   <= 3'd0;
            rcv_q   <= 3'd0;
            pend_q  <= 1'b0;
            drop_q  <= grant;
            valid_q <= 1'b0;
            jmp_q   <= 1'b0;
        end else begin
            pend_q <= grant;
            drop_q <= 1'b0;
            case (state_q)
                IF_IDLE: state_q <= IF_FETCH;
                IF_FETCH: begin
                    if (grant) iss_q <= iss_q + 3'd1;
                    if (byte_ok) begin
                        rcv_q <= rcv_q + 3'd1;
                        if (rcv_q == 3'd3) begin
                            pc_q    <= fpc_q;
                            inst_q  <= word_d;
                            valid_q <= 1'b1;
                            jmp_q   <= pred_taken;
                            fpc_q   <= pred_next_pc;
                            state_q <= IF_WAIT;
                        end
                    end
                end
                IF_WAIT: begin
                    if (!stall_i) begin
                        valid_q <= 1'b0;
                        iss_q   <= 3'd0;
                        rcv_q   <= 3'd0;
                        state_q <= IF_FETCH;
                    end
                end
                default: state_q <= IF_IDLE;
            endcase
        end
    end

endmodule
